nibble_serial_adder: RTL

//  - Multi-cycle WIDTH-bit adder built around one instance of the team's 4-bit carry-lookahead slice, CLA_4bit.
//  - Feeds CLA_4bit one nibble per cycle, LSB nibble first, and registers the slice carry between cycles.
//  - Used where area beats latency: operand capture and result return use a valid/ready handshake on each side.

---
 rtl/nibble_serial_adder.sv | 128 ++++++++++++
 1 files changed

// File: rtl/nibble_serial_adder.sv
// Nibble-serial WIDTH-bit adder: one CLA_4bit slice reused once per nibble, LSB first.
// Optional macro SUBTRACT_EN adds the sub port (a - b via ~b and carry-in of 1).

module CLA_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       c_in,
  output logic [3:0] s,
  output logic       c_out
);
  logic [3:0] g, p;
  logic [4:0] c;

  assign g = a & b;
  assign p = a ^ b;
  assign c[0] = c_in;
  assign c[1] = g[0] | (p[0] & c[0]);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & c[0]);
  assign s     = p ^ c[3:0];
  assign c_out = c[4];
endmodule

module nibble_serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
`ifdef SUBTRACT_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             busy
);
  localparam int NIBBLES = WIDTH / 4;
  localparam int CNT_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  generate
    if (WIDTH < 4 || (WIDTH % 4) != 0) begin : g_bad_width
      $error("nibble_serial_adder: WIDTH must be a multiple of 4 and >= 4");
    end
  endgenerate

  logic [1:0]       state;
  logic [WIDTH-1:0] a_sr, b_sr, sum_r;
  logic             carry_r, c_out_r;
  logic [CNT_W-1:0] cnt;

  logic [3:0]       slice_s;
  logic             slice_co;
  logic [WIDTH+3:0] sum_cat;
  logic [WIDTH-1:0] b_load;
  logic             cin_load;

  CLA_4bit u_slice (
    .a    (a_sr[3:0]),
    .b    (b_sr[3:0]),
    .c_in (carry_r),
    .s    (slice_s),
    .c_out(slice_co)
  );

  // New nibble enters at the top; after NIBBLES passes the LSB nibble lands at bit 0.
  assign sum_cat = {slice_s, sum_r};

`ifdef SUBTRACT_EN
  assign b_load   = sub ? ~b : b;
  assign cin_load = sub ? 1'b1 : c_in;
`else
  assign b_load   = b;
  assign cin_load = c_in;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      a_sr    <= '0;
      b_sr    <= '0;
      sum_r   <= '0;
      carry_r <= 1'b0;
      c_out_r <= 1'b0;
      cnt     <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          a_sr    <= a;
          b_sr    <= b_load;
          carry_r <= cin_load;
          cnt     <= '0;
          state   <= RUN;
        end
        RUN: begin
          sum_r   <= sum_cat[WIDTH+3:4];
          a_sr    <= a_sr >> 4;
          b_sr    <= b_sr >> 4;
          carry_r <= slice_co;
          cnt     <= cnt + 1'b1;
          if (cnt == CNT_W'(NIBBLES - 1)) begin
            c_out_r <= slice_co;
            state   <= DONE;
          end
        end
        DONE: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign sum       = sum_r;
  assign c_out     = c_out_r;
endmodule
